mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single-port `Memory` between the `Core` (master 0) and the test/debug controller (master 1). Each master gets a request/ack handshake. The arbiter serialises accesses, drives exactly one memory strobe per transaction and returns registered read data. Optional exclusive lock lets the controller own memory while the core is paused. Out-of-range addresses are rejected without touching memory.

## Interface
- `MEM_LATENCY`, 1: cycles from `memory_read` strobe to valid `memory_read_data` (≥1).
- `MEMORY_SIZE`, 4096: memory depth in 32-bit words; valid byte addresses are 0 to `MEMORY_SIZE*4-1`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `m0_req`, `m1_req` in 1: transaction request, held until ack.
- `m0_write`, `m1_write` in 1: 1 = write, 0 = read; sampled with req.
- `m0_address`, `m1_address` in 32: byte address.
- `m0_write_data`, `m1_write_data` in 32: write data.
- `m0_read_data`, `m1_read_data` out 32: registered read data, valid in ack cycle.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: one-cycle pulse with ack on out-of-range address.
- `lock_m1` in 1: when high, master 0 is never granted.
- `memory_read`, `memory_write` out 1: one-cycle strobes, mutually exclusive.
- `memory_address`, `memory_write_data` out 32: held stable from ISSUE through end of transaction.
- `memory_read_data` in 32: memory return data.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Sample requests; master 0's request is masked while `lock_m1` is high.
  - If one request is eligible, grant it. If both are, grant the master that did not win last (round-robin `last_grant`; reset value 1, so the core wins first contention).
  - Latch grant, write, address and write data into registers, then go to ISSUE. Otherwise stay.
- **ISSUE**
  - If the latched address ≥ `MEMORY_SIZE*4`: no strobe, set err, go to RESP.
  - Otherwise assert `memory_write` (write) or `memory_read` (read) for this cycle only.
  - Write goes to RESP. Read loads the latency counter with `MEM_LATENCY-1` and goes to WAIT.
- **WAIT**
  - If the counter is 0: capture `memory_read_data` into the granted master's read_data register, go to RESP. Otherwise decrement.
- **RESP**
  - Pulse the granted master's ack (and err if flagged), update `last_grant`, go to IDLE.
  - Error reads return read_data = 0. Writes leave read_data unchanged.
- Requester rule: drop req on the edge where ack is seen. A req still high in IDLE starts a new transaction.
- Changing req, address or data before ack is ignored; values were latched in IDLE.
- `lock_m1` rising mid-transaction does not abort the master-0 transaction. It only affects the next IDLE arbitration.

## Timing
- Reset values:
  - All strobes, acks, errs and `busy` = 0.
  - Read data registers, `memory_address` and `memory_write_data` = 0.
  - State IDLE, `last_grant` = 1, counter = 0.
- Read, req first seen in IDLE cycle T: strobe at T+1, data captured at end of T+1+`MEM_LATENCY`, ack at T+2+`MEM_LATENCY` (T+3 when L=1).
- Write: strobe at T+1, ack at T+2.
- Error: ack+err at T+2, no strobe.
- Minimum spacing between back-to-back transactions is one IDLE cycle.
- Simultaneous requests with `lock_m1` low alternate grants strictly.
- Reset mid-transaction: return to IDLE on that edge. Pending transaction dropped, no ack, strobes low the next cycle.

## Structure
- Package `mem_arbiter_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), master index constants `M_CORE`=0 and `M_CTRL`=1, and the 32-bit data/address width constant.
- One combinational sub-module, `arb_rr_select`: inputs are the eligible request vector and `last_grant`; outputs are the grant index and a valid flag. Everything else lives in the top FSM.

## Test plan
- Core read of address 0x10 (word 4 = 0xDEADBEEF), L=1 → `memory_read` pulse at T+1, `m0_ack` at T+3 with `m0_read_data` = 0xDEADBEEF, `m1_ack` never high.
- Controller write 0x12345678 to 0x20, then read back → `memory_write` pulse one cycle with address 0x20, `m1_ack` at T+2, readback returns 0x12345678.
- Both masters request continuously for 6 transactions → grant order 0,1,0,1,0,1 and no strobe overlap.
- `lock_m1`=1 with both requesting → only master 1 is acked. Drop lock → master 0 is acked next.
- Read at 0x4000 with `MEMORY_SIZE`=4096 → no strobe, ack+err at T+2, read_data = 0.
- Reset asserted in WAIT with `MEM_LATENCY`=3 → FSM in IDLE next cycle, no ack, all outputs at reset values.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic M_CORE = 1'b0;
  localparam logic M_CTRL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // One latched master transaction.
  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
  } mem_req_t;

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin pick: the master that did not win last gets contended grants.
module arb_rr_select
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_c,
  output logic       valid_c
);

  always_comb begin
    grant_c = M_CORE;
    valid_c = |req;
    if (&req) begin
      grant_c = ~last_grant;
    end else if (req[1]) begin
      grant_c = M_CTRL;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises core and controller accesses onto a single-port memory with
// registered strobes, acks and read data; out-of-range requests bypass memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MEMORY_SIZE = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_write_data,
  output logic [DATA_W-1:0] m0_read_data,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              m1_ack,
  output logic              m1_err,
  input  logic              lock_m1,
  output logic              memory_read,
  output logic              memory_write,
  output logic [DATA_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_write_data,
  input  logic [DATA_W-1:0] memory_read_data,
  output logic              busy
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned AW1   = DATA_W + 1;
  localparam logic [AW1-1:0] ADDR_LIMIT = AW1'(MEMORY_SIZE) << 2;

  arb_state_t       state;
  mem_req_t         req_q;
  logic             grant_q;
  logic             err_q;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic [1:0] eligible;
  logic       sel_grant;
  logic       sel_valid;
  mem_req_t   sel_req;
  logic       sel_in_range;

  assign eligible = {m1_req, m0_req & ~lock_m1};

  arb_rr_select u_select (
    .req        (eligible),
    .last_grant (last_grant),
    .grant_c    (sel_grant),
    .valid_c    (sel_valid)
  );

  always_comb begin
    if (sel_grant == M_CTRL) begin
      sel_req.write      = m1_write;
      sel_req.address    = m1_address;
      sel_req.write_data = m1_write_data;
    end else begin
      sel_req.write      = m0_write;
      sel_req.address    = m0_address;
      sel_req.write_data = m0_write_data;
    end
  end

  assign sel_in_range = {1'b0, sel_req.address} < ADDR_LIMIT;

  assign memory_address    = req_q.address;
  assign memory_write_data = req_q.write_data;

  // Strobes are registered, so the range check is resolved on the grant edge
  // and the strobe appears exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= '0;
      grant_q      <= M_CORE;
      err_q        <= 1'b0;
      last_grant   <= M_CTRL;
      cnt          <= '0;
      memory_read  <= 1'b0;
      memory_write <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_read_data <= '0;
      m1_read_data <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant_q      <= sel_grant;
            req_q        <= sel_req;
            err_q        <= ~sel_in_range;
            memory_read  <= sel_in_range & ~sel_req.write;
            memory_write <= sel_in_range & sel_req.write;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          memory_read  <= 1'b0;
          memory_write <= 1'b0;
          if (err_q || req_q.write) begin
            m0_ack <= (grant_q == M_CORE);
            m1_ack <= (grant_q == M_CTRL);
            m0_err <= err_q && (grant_q == M_CORE);
            m1_err <= err_q && (grant_q == M_CTRL);
            if (err_q && !req_q.write) begin
              if (grant_q == M_CTRL) m1_read_data <= '0;
              else                   m0_read_data <= '0;
            end
            state <= RESP;
          end else begin
            cnt   <= CNT_W'(MEM_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (grant_q == M_CTRL) m1_read_data <= memory_read_data;
            else                   m0_read_data <= memory_read_data;
            m0_ack <= (grant_q == M_CORE);
            m1_ack <= (grant_q == M_CTRL);
            state  <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          m0_ack     <= 1'b0;
          m1_ack     <= 1'b0;
          m0_err     <= 1'b0;
          m1_err     <= 1'b0;
          last_grant <= grant_q;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (latency 1 and latency 3 instances).
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write, lock_m1;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        memory_read, memory_write, busy;
  logic [31:0] memory_address, memory_write_data, memory_read_data;

  logic        reset3, m0_req3;
  logic [31:0] m0_address3;
  logic [31:0] m0_read_data3, m1_read_data3;
  logic        m0_ack3, m1_ack3, m0_err3, m1_err3;
  logic        memory_read3, memory_write3, busy3;
  logic [31:0] memory_address3, memory_write_data3, memory_read_data3;

  logic [31:0] mem [0:4095];

  int n_checks;
  int n_fail;

  mem_arbiter #(.MEM_LATENCY(1), .MEMORY_SIZE(4096)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .lock_m1(lock_m1),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(3), .MEMORY_SIZE(4096)) dut3 (
    .clk(clk), .reset(reset3),
    .m0_req(m0_req3), .m0_write(1'b0), .m0_address(m0_address3),
    .m0_write_data(32'h0), .m0_read_data(m0_read_data3),
    .m0_ack(m0_ack3), .m0_err(m0_err3),
    .m1_req(1'b0), .m1_write(1'b0), .m1_address(32'h0),
    .m1_write_data(32'h0), .m1_read_data(m1_read_data3),
    .m1_ack(m1_ack3), .m1_err(m1_err3),
    .lock_m1(1'b0),
    .memory_read(memory_read3), .memory_write(memory_write3),
    .memory_address(memory_address3), .memory_write_data(memory_write_data3),
    .memory_read_data(memory_read_data3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 memory: data registered on the strobe edge, valid the next cycle.
  always @(posedge clk) begin
    if (reset) begin
      mem[4]    <= 32'hDEADBEEF;
      mem[4095] <= 32'hCAFEF00D;
    end else begin
      if (memory_write) mem[memory_address[13:2]] <= memory_write_data;
      if (memory_read)  memory_read_data <= mem[memory_address[13:2]];
    end
  end

  // Latency-3 memory returns an address-derived pattern.
  assign memory_read_data3 = 32'hA500_0000 | memory_address3;

  task automatic test_reset();
    reset = 1'b1; reset3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_checks++; if ({memory_read, memory_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {memory_read, memory_write}); end
    n_checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    n_checks++; if (memory_address !== 32'h0 || memory_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", memory_address, memory_write_data); end
    n_checks++; if (m0_read_data !== 32'h0 || m1_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_read_data, m1_read_data); end
    reset = 1'b0; reset3 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %h want 0", busy); end
  endtask

  task automatic test_core_read();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 32'h10;
    @(posedge clk); #1;
    n_checks++; if ({memory_read, memory_write} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe_t1: got %b want 10", {memory_read, memory_write}); end
    n_checks++; if (memory_address !== 32'h10) begin n_fail++; $display("FAIL rd_addr_t1: got %h want 00000010", memory_address); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_t1: got %h want 1", busy); end
    @(posedge clk); #1;
    n_checks++; if ({memory_read, m0_ack, m1_ack} !== 3'b000) begin n_fail++; $display("FAIL rd_t2: got %b want 000", {memory_read, m0_ack, m1_ack}); end
    @(posedge clk); #1;
    n_checks++; if ({m0_ack, m0_err, m1_ack} !== 3'b100) begin n_fail++; $display("FAIL rd_ack_t3: got %b want 100", {m0_ack, m0_err, m1_ack}); end
    n_checks++; if (m0_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", m0_read_data); end
    m0_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({m0_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL rd_after: got %b want 00", {m0_ack, busy}); end
  endtask

  task automatic test_ctrl_write_readback();
    @(posedge clk); #1;
    m1_req = 1'b1; m1_write = 1'b1; m1_address = 32'h20; m1_write_data = 32'h12345678;
    @(posedge clk); #1;
    n_checks++; if ({memory_read, memory_write} !== 2'b01) begin n_fail++; $display("FAIL wr_strobe_t1: got %b want 01", {memory_read, memory_write}); end
    n_checks++; if (memory_address !== 32'h20 || memory_write_data !== 32'h12345678) begin n_fail++; $display("FAIL wr_bus_t1: got %h/%h want 00000020/12345678", memory_address, memory_write_data); end
    m1_write_data = 32'hFFFF0000;
    @(posedge clk); #1;
    n_checks++; if ({memory_write, m1_ack, m1_err, m0_ack} !== 4'b0100) begin n_fail++; $display("FAIL wr_ack_t2: got %b want 0100", {memory_write, m1_ack, m1_err, m0_ack}); end
    n_checks++; if (memory_write_data !== 32'h12345678) begin n_fail++; $display("FAIL wr_data_held: got %h want 12345678", memory_write_data); end
    m1_req = 1'b0;
    @(posedge clk); #1;
    m1_req = 1'b1; m1_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m1_ack !== 1'b1) begin n_fail++; $display("FAIL rb_ack_t3: got %h want 1", m1_ack); end
    n_checks++; if (m1_read_data !== 32'h12345678) begin n_fail++; $display("FAIL rb_data: got %h want 12345678", m1_read_data); end
    m1_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int order[$];
    int overlaps;
    overlaps = 0;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 32'h10;
    m1_req = 1'b1; m1_write = 1'b0; m1_address = 32'h20;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (memory_read && memory_write) overlaps++;
      if (m0_ack) begin
        order.push_back(0);
        n_checks++; if (m0_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_m0_data: got %h want deadbeef", m0_read_data); end
      end
      if (m1_ack) begin
        order.push_back(1);
        n_checks++; if (m1_read_data !== 32'h12345678) begin n_fail++; $display("FAIL b2b_m1_data: got %h want 12345678", m1_read_data); end
      end
      if (order.size() >= 6) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    n_checks++; if (order.size() != 6) begin n_fail++; $display("FAIL b2b_count: got %0d acks want 6 (timeout or double ack)", order.size()); end
    n_checks++; if (overlaps != 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d overlapping strobes want 0", overlaps); end
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] != (i % 2)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
    end
  endtask

  task automatic test_lock();
    int m1_acks;
    int m0_acks_locked;
    int next_master;
    m1_acks = 0; m0_acks_locked = 0; next_master = -1;
    @(posedge clk); #1;
    lock_m1 = 1'b1;
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 32'h10;
    m1_req = 1'b1; m1_write = 1'b0; m1_address = 32'h20;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (lock_m1) begin
        if (m0_ack) m0_acks_locked++;
        if (m1_ack) m1_acks++;
        if (m1_acks == 3) lock_m1 = 1'b0;
      end else if (m0_ack || m1_ack) begin
        next_master = m1_ack ? 1 : 0;
        break;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; lock_m1 = 1'b0;
    n_checks++; if (m1_acks != 3) begin n_fail++; $display("FAIL lock_m1_acks: got %0d want 3", m1_acks); end
    n_checks++; if (m0_acks_locked != 0) begin n_fail++; $display("FAIL lock_m0_blocked: got %0d acks want 0", m0_acks_locked); end
    n_checks++; if (next_master != 0) begin n_fail++; $display("FAIL unlock_next: got %0d want 0", next_master); end
  endtask

  task automatic test_range();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 32'h3FFC;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({m0_ack, m0_err} !== 2'b10 || m0_read_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL last_word: got ack/err %b data %h want 10 cafef00d", {m0_ack, m0_err}, m0_read_data); end
    m0_req = 1'b0;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_address = 32'h4000;
    @(posedge clk); #1;
    n_checks++; if ({memory_read, memory_write, busy} !== 3'b001) begin n_fail++; $display("FAIL err_rd_t1: got %b want 001", {memory_read, memory_write, busy}); end
    @(posedge clk); #1;
    n_checks++; if ({m0_ack, m0_err, memory_read} !== 3'b110) begin n_fail++; $display("FAIL err_rd_t2: got %b want 110", {m0_ack, m0_err, memory_read}); end
    n_checks++; if (m0_read_data !== 32'h0) begin n_fail++; $display("FAIL err_rd_data: got %h want 0", m0_read_data); end
    m0_req = 1'b0;
    @(posedge clk); #1;
    m1_req = 1'b1; m1_write = 1'b1; m1_address = 32'hFFFF_FFF0; m1_write_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    n_checks++; if ({memory_read, memory_write} !== 2'b00) begin n_fail++; $display("FAIL err_wr_t1: got %b want 00", {memory_read, memory_write}); end
    @(posedge clk); #1;
    n_checks++; if ({m1_ack, m1_err, m0_err} !== 3'b110) begin n_fail++; $display("FAIL err_wr_t2: got %b want 110", {m1_ack, m1_err, m0_err}); end
    n_checks++; if (m1_read_data !== 32'h12345678) begin n_fail++; $display("FAIL err_wr_rdata: got %h want 12345678", m1_read_data); end
    m1_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({m1_ack, m1_err} !== 2'b00) begin n_fail++; $display("FAIL err_pulse_len: got %b want 00", {m1_ack, m1_err}); end
  endtask

  task automatic test_latency3();
    @(posedge clk); #1;
    m0_req3 = 1'b1; m0_address3 = 32'h10;
    @(posedge clk); #1;
    n_checks++; if (memory_read3 !== 1'b1) begin n_fail++; $display("FAIL l3_strobe: got %h want 1", memory_read3); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m0_ack3 !== 1'b0 || busy3 !== 1'b1) begin n_fail++; $display("FAIL l3_t4: got ack %h busy %h want 0 1", m0_ack3, busy3); end
    @(posedge clk); #1;
    n_checks++; if (m0_ack3 !== 1'b1 || m0_read_data3 !== 32'hA5000010) begin n_fail++; $display("FAIL l3_ack_t5: got ack %h data %h want 1 a5000010", m0_ack3, m0_read_data3); end
    m0_req3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    @(posedge clk); #1;
    m0_req3 = 1'b1; m0_address3 = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (busy3 !== 1'b1 || memory_read3 !== 1'b0) begin n_fail++; $display("FAIL mid_wait: got busy %h rd %h want 1 0", busy3, memory_read3); end
    reset3 = 1'b1;
    @(posedge clk); #1;
    reset3 = 1'b0; m0_req3 = 1'b0;
    n_checks++; if ({busy3, m0_ack3, m0_err3, memory_read3, memory_write3} !== 5'b00000) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b want 00000", {busy3, m0_ack3, m0_err3, memory_read3, memory_write3}); end
    n_checks++; if (memory_address3 !== 32'h0 || m0_read_data3 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data: got %h/%h want 0/0", memory_address3, m0_read_data3); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (m0_ack3) acks++;
    end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL mid_rst_noack: got %0d acks want 0", acks); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; reset3 = 1'b1; lock_m1 = 1'b0;
    m0_req = 1'b0; m0_write = 1'b0; m0_address = '0; m0_write_data = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_address = '0; m1_write_data = '0;
    m0_req3 = 1'b0; m0_address3 = '0;
    test_reset();
    test_core_read();
    test_ctrl_write_readback();
    test_back_to_back();
    test_lock();
    test_range();
    test_latency3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
